serial_adder: RTL

- Bit-serial WIDTH-bit adder for the SimpleALU; the additive counterpart to the combinational subtractor.
- Latches two operands on a start pulse, adds one bit per clock LSB-first through a single full-adder cell, then presents sum and carry-out with a one-cycle done strobe.
- Trades latency for area. It sits beside the subtractor under the ALU op-select, and the ALU sequencer drives its start/done handshake.

---
 rtl/alu_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Types and defaults shared by the SimpleALU arithmetic units.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the bit-serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, through a single
// full-adder cell. Result and carry are held until the next completion.
module serial_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             fa_s, fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept   = start_i && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == LAST);
  assign res_next = {fa_s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start_i ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else if (accept) begin
      a_sr    <= a_i;
      b_sr    <= b_i;
      res_sr  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_next;
      carry_q <= fa_cout;
      cnt     <= cnt + CW'(1);
      // The final bit lands straight in sum_o so the result is ready with done.
      if (last_bit) begin
        sum_o   <= res_next;
        carry_o <= fa_cout;
      end
    end
  end

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

endmodule
